// File: rtl/writeback_queue.sv
// Writeback stage: in-order queue merging ALU and memory results onto the register bank
// write port, with a pending-write probe for operand-fetch hazard detection.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_SEL
`define REG_SEL 5
`endif
`ifndef PRED_REG_SEL
`define PRED_REG_SEL 3
`endif
`ifndef S_REGS
`define S_REGS 1'b0
`endif
`ifndef P_REGS
`define P_REGS 1'b1
`endif

module writeback_queue #(
  parameter int DEPTH        = 4,
  parameter int WIDTH        = `WIDTH,
  parameter int REG_SEL      = `REG_SEL,
  parameter int PRED_REG_SEL = `PRED_REG_SEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [REG_SEL-1:0] alu_addr,
  input  logic               alu_sel,
  input  logic [WIDTH-1:0]   alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [REG_SEL-1:0] mem_addr,
  input  logic               mem_sel,
  input  logic [WIDTH-1:0]   mem_data,
  output logic               write_enable,
  output logic [REG_SEL-1:0] z_regbank_addr,
  output logic               z_regbank_sel,
  output logic [WIDTH-1:0]   z_data,
  input  logic [REG_SEL-1:0] query_addr,
  input  logic               query_sel,
  output logic               busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic [PW-1:0]      head_reg;
  logic [PW-1:0]      tail_reg;
  logic [PW-1:0]      mem_slot;
  logic               alu_push;
  logic               mem_push;
  logic               pop;

  logic [REG_SEL-1:0] addr_mem [DEPTH];
  logic               sel_mem  [DEPTH];
  logic [WIDTH-1:0]   data_mem [DEPTH];

  // Predicate registers only decode the low PRED_REG_SEL address bits.
  function automatic logic reg_match(input logic [REG_SEL-1:0] a, input logic s,
                                     input logic [REG_SEL-1:0] qa, input logic qs);
    return (s == qs) &&
           ((qs == `P_REGS) ? (a[PRED_REG_SEL-1:0] == qa[PRED_REG_SEL-1:0]) : (a == qa));
  endfunction

  // Ready looks only at the registered count; the pop of this edge gives no credit.
  assign alu_ready  = (count_reg < FULL);
  assign mem_ready  = (count_reg < ALMOST) || ((count_reg < FULL) && !alu_valid);
  assign alu_push   = alu_valid && alu_ready;
  assign mem_push   = mem_valid && mem_ready;
  assign pop        = (count_reg != '0);
  assign mem_slot   = tail_reg + PW'(alu_push);
  assign count_next = count_reg + CW'(alu_push) + CW'(mem_push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (alu_push) begin
      addr_mem[tail_reg] <= alu_addr;
      sel_mem[tail_reg]  <= alu_sel;
      data_mem[tail_reg] <= alu_data;
    end
    if (mem_push) begin
      addr_mem[mem_slot] <= mem_addr;
      sel_mem[mem_slot]  <= mem_sel;
      data_mem[mem_slot] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg      <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      write_enable   <= 1'b0;
      z_regbank_addr <= '0;
      z_regbank_sel  <= 1'b0;
      z_data         <= '0;
    end else begin
      count_reg    <= count_next;
      tail_reg     <= tail_reg + PW'(alu_push) + PW'(mem_push);
      write_enable <= pop;
      if (pop) begin
        head_reg       <= head_reg + PW'(1);
        z_regbank_addr <= addr_mem[head_reg];
        z_regbank_sel  <= sel_mem[head_reg];
        z_data         <= data_mem[head_reg];
      end
    end
  end

  // An entry is live when its distance from head is below the occupancy count.
  logic [DEPTH-1:0] entry_hit;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] offset;
      assign offset = PW'(gi) - head_reg;
      assign entry_hit[gi] = ({1'b0, offset} < count_reg) &&
                             reg_match(addr_mem[gi], sel_mem[gi], query_addr, query_sel);
    end
  endgenerate

  assign busy = (|entry_hit) ||
                (write_enable && reg_match(z_regbank_addr, z_regbank_sel, query_addr, query_sel));

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based reference model.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_SEL
`define REG_SEL 5
`endif
`ifndef PRED_REG_SEL
`define PRED_REG_SEL 3
`endif
`ifndef S_REGS
`define S_REGS 1'b0
`endif
`ifndef P_REGS
`define P_REGS 1'b1
`endif

module tb_writeback_queue;
  localparam int DEPTH        = 4;
  localparam int WIDTH        = `WIDTH;
  localparam int REG_SEL      = `REG_SEL;
  localparam int PRED_REG_SEL = `PRED_REG_SEL;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               alu_valid = 1'b0;
  logic               alu_ready;
  logic [REG_SEL-1:0] alu_addr = '0;
  logic               alu_sel = 1'b0;
  logic [WIDTH-1:0]   alu_data = '0;
  logic               mem_valid = 1'b0;
  logic               mem_ready;
  logic [REG_SEL-1:0] mem_addr = '0;
  logic               mem_sel = 1'b0;
  logic [WIDTH-1:0]   mem_data = '0;
  logic               write_enable;
  logic [REG_SEL-1:0] z_regbank_addr;
  logic               z_regbank_sel;
  logic [WIDTH-1:0]   z_data;
  logic [REG_SEL-1:0] query_addr = '0;
  logic               query_sel = 1'b0;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REG_SEL(REG_SEL),
                    .PRED_REG_SEL(PRED_REG_SEL)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_sel(alu_sel), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_data(mem_data),
    .write_enable(write_enable), .z_regbank_addr(z_regbank_addr),
    .z_regbank_sel(z_regbank_sel), .z_data(z_data),
    .query_addr(query_addr), .query_sel(query_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of accepted results plus the expected output stage.
  typedef struct packed {
    logic [REG_SEL-1:0] addr;
    logic               sel;
    logic [WIDTH-1:0]   data;
  } wb_t;

  wb_t  mq[$];
  logic exp_we = 1'b0;
  wb_t  exp_out = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      exp_we  = 1'b0;
      exp_out = '0;
    end else begin
      int   n;
      logic ar;
      logic mr;
      wb_t  e;
      n  = mq.size();
      ar = (n < DEPTH);
      mr = (n < DEPTH - 1) || ((n < DEPTH) && !alu_valid);
      if (n > 0) begin
        exp_we  = 1'b1;
        exp_out = mq.pop_front();
      end else begin
        exp_we = 1'b0;
      end
      if (alu_valid && ar) begin
        e.addr = alu_addr; e.sel = alu_sel; e.data = alu_data;
        mq.push_back(e);
      end
      if (mem_valid && mr) begin
        e.addr = mem_addr; e.sel = mem_sel; e.data = mem_data;
        mq.push_back(e);
      end
    end
  end

  function automatic logic hit(input logic [REG_SEL-1:0] a, input logic s);
    int m;
    m = 1 << PRED_REG_SEL;
    if (s != query_sel) return 1'b0;
    if (s == `P_REGS) return (int'(a) % m) == (int'(query_addr) % m);
    return a == query_addr;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    foreach (mq[i]) if (hit(mq[i].addr, mq[i].sel)) b = 1'b1;
    if (exp_we && hit(exp_out.addr, exp_out.sel)) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    chk("alu_ready", 64'(alu_ready), 64'(n < DEPTH));
    chk("mem_ready", 64'(mem_ready), 64'((n < DEPTH - 1) || ((n < DEPTH) && !alu_valid)));
    chk("write_enable", 64'(write_enable), 64'(exp_we));
    chk("z_regbank_addr", 64'(z_regbank_addr), 64'(exp_out.addr));
    chk("z_regbank_sel", 64'(z_regbank_sel), 64'(exp_out.sel));
    chk("z_data", 64'(z_data), 64'(exp_out.data));
    chk("busy", 64'(busy), 64'(m_busy()));
    if (write_enable)
      $display("wb sel=%0d addr=%0d data=%08h t=%0t", z_regbank_sel, z_regbank_addr, z_data, $time);
  endtask

  // Inputs change at posedge+1; each tick compares at the negedge, then steps past the next edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_in(input logic v, input int a, input logic s, input logic [WIDTH-1:0] d);
    alu_valid = v; alu_addr = REG_SEL'(a); alu_sel = s; alu_data = d;
  endtask

  task automatic mem_in(input logic v, input int a, input logic s, input logic [WIDTH-1:0] d);
    mem_valid = v; mem_addr = REG_SEL'(a); mem_sel = s; mem_data = d;
  endtask

  task automatic query(input int a, input logic s);
    query_addr = REG_SEL'(a); query_sel = s;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_addr", 64'(z_regbank_addr), 64'd0);
    chk("rst_data", 64'(z_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    reset = 1'b1;

    // Single ALU push to r3.
    alu_in(1'b1, 3, `S_REGS, 32'hDEADBEEF);
    query(3, `S_REGS);
    tick();
    idle();
    #1;
    chk("t1_we_early", 64'(write_enable), 64'd0);
    chk("t1_busy_queued", 64'(busy), 64'd1);
    tick();
    chk("t1_we", 64'(write_enable), 64'd1);
    chk("t1_addr", 64'(z_regbank_addr), 64'd3);
    chk("t1_data", 64'(z_data), 64'hDEADBEEF);
    tick();
    chk("t1_we_off", 64'(write_enable), 64'd0);

    // ALU and memory together: ALU drains first.
    alu_in(1'b1, 1, `S_REGS, 32'h11);
    mem_in(1'b1, 2, `S_REGS, 32'h22);
    tick();
    idle();
    tick();
    chk("t2_first_addr", 64'(z_regbank_addr), 64'd1);
    chk("t2_first_data", 64'(z_data), 64'h11);
    tick();
    chk("t2_second_addr", 64'(z_regbank_addr), 64'd2);
    chk("t2_second_data", 64'(z_data), 64'h22);
    tick();
    chk("t2_we_off", 64'(write_enable), 64'd0);

    // Sustained dual pushes: at occupancy DEPTH-1 memory waits for the ALU.
    alu_in(1'b1, 10, `S_REGS, 32'h31);
    mem_in(1'b1, 11, `S_REGS, 32'h41);
    tick();
    alu_in(1'b1, 12, `S_REGS, 32'h32);
    mem_in(1'b1, 13, `S_REGS, 32'h42);
    tick();
    alu_in(1'b1, 14, `S_REGS, 32'h33);
    mem_in(1'b1, 15, `S_REGS, 32'h43);
    #1;
    chk("t3_alu_ready", 64'(alu_ready), 64'd1);
    chk("t3_mem_blocked", 64'(mem_ready), 64'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("t3_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    idle();
    repeat (5) tick();

    // Predicate register pending-write probe.
    alu_in(1'b1, 1, `P_REGS, 32'hFFFFFFFE);
    query(1, `P_REGS);
    tick();
    idle();
    #1;
    chk("t4_busy_queued", 64'(busy), 64'd1);
    tick();
    chk("t4_we", 64'(write_enable), 64'd1);
    chk("t4_sel", 64'(z_regbank_sel), 64'd1);
    chk("t4_data", 64'(z_data), 64'hFFFFFFFE);
    chk("t4_busy_out", 64'(busy), 64'd1);
    query(1, `S_REGS);
    #1;
    chk("t4_busy_sbank", 64'(busy), 64'd0);
    query(9, `P_REGS);
    #1;
    chk("t4_busy_alias", 64'(busy), 64'd1);
    tick();
    query(1, `P_REGS);
    #1;
    chk("t4_busy_done", 64'(busy), 64'd0);

    // Stream across pointer wrap, then two writes to r5.
    for (int i = 0; i < 10; i++) begin
      alu_in(1'b1, i, `S_REGS, WIDTH'(32'h100 + i));
      tick();
      if (i >= 1) begin
        chk("t5_addr", 64'(z_regbank_addr), 64'(i - 1));
        chk("t5_data", 64'(z_data), 64'(32'h100 + i - 1));
      end
    end
    alu_in(1'b1, 5, `S_REGS, 32'hA);
    tick();
    chk("t5_last_addr", 64'(z_regbank_addr), 64'd9);
    alu_in(1'b1, 5, `S_REGS, 32'hB);
    tick();
    chk("t5_r5_first", 64'(z_data), 64'hA);
    idle();
    tick();
    chk("t5_r5_second", 64'(z_data), 64'hB);
    tick();

    // Asynchronous reset mid-drain with three entries queued.
    alu_in(1'b1, 20, `S_REGS, 32'h61);
    mem_in(1'b1, 21, `S_REGS, 32'h62);
    tick();
    alu_in(1'b1, 22, `S_REGS, 32'h63);
    mem_in(1'b1, 23, `S_REGS, 32'h64);
    tick();
    idle();
    query(22, `S_REGS);
    #1;
    chk("t6_busy_before", 64'(busy), 64'd1);
    chk("t6_we_before", 64'(write_enable), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_we_rst", 64'(write_enable), 64'd0);
    chk("t6_addr_rst", 64'(z_regbank_addr), 64'd0);
    chk("t6_data_rst", 64'(z_data), 64'd0);
    chk("t6_sel_rst", 64'(z_regbank_sel), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_write", 64'(write_enable), 64'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      alu_in($urandom_range(0, 99) < 60, $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom);
      mem_in($urandom_range(0, 99) < 60, $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom);
      query($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      tick();
    end
    idle();
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
